nios2_cpu_debug_ocimem_ctrl: RTL and testbench
==============================================

// Module: nios2_cpu_debug_ocimem_ctrl
// PURPOSE
//  Downstream consumer of the debug-slave sysclk strobes: turns take_action_ocimem_a/b and
//  take_no_action_ocimem_a plus the 38-bit jdo word into read/write cycles on the on-chip
//  debug memory. It holds the monitor address (MonAReg) and data (MonDReg) registers.
//  MonDReg feeds back to the debug slave tck stage for JTAG capture.
// PARAMETERS
//  ADDR_W   8   word-address width of the debug memory (1..14)
//  TIMEOUT  15  max clk cycles to wait for mem_ready before aborting (4-bit counter, 1..15)
// PORTS
//  clk                      in   1       system clock; all logic on rising edge
//  reset_n                  in   1       asynchronous active-low reset
//  jdo                      in   38      JTAG data word, valid while any strobe is high
//  take_action_ocimem_a     in   1       1-cycle strobe: load address, optional read
//  take_no_action_ocimem_a  in   1       1-cycle strobe: read at MonAReg, then increment
//  take_action_ocimem_b     in   1       1-cycle strobe: write jdo data at MonAReg, then increment
//  mem_addr                 out  ADDR_W  memory word address
//  mem_wdata                out  32      memory write data
//  mem_we                   out  1       write request, held until mem_ready
//  mem_re                   out  1       read request, held until mem_ready
//  mem_rdata                in   32      read data, valid in the cycle mem_ready=1 with mem_re
//  mem_ready                in   1       memory accepts/completes the current request
//  MonDReg                  out  32      monitor data register
//  MonAReg                  out  ADDR_W  monitor address register
//  busy                     out  1       FSM not in IDLE
//  cmd_overrun              out  1       sticky: strobe arrived while busy and was dropped
//  mem_timeout              out  1       sticky: request aborted after TIMEOUT cycles
// BEHAVIOUR
//  Reset: every output is 0; FSM goes to IDLE; timeout counter is 0.
//  Commands are decoded only in IDLE. Priority: ocimem_b > ocimem_a > no_action_a.
//   ocimem_a: MonAReg <= jdo[17+ADDR_W-1:17]. If jdo[35]=1, go to RD with mem_addr = the new
//     address. No increment after an ocimem_a read.
//   no_action_a: go to RD with mem_addr = MonAReg. On completion MonAReg <= MonAReg+1.
//   ocimem_b: MonDReg <= jdo[34:3], mem_wdata <= jdo[34:3]. Go to WR with mem_addr = MonAReg.
//     On completion MonAReg <= MonAReg+1.
//  FSM states: IDLE, RD, WR. The cycle after the strobe is in RD/WR.
//   mem_re=1 in RD, mem_we=1 in WR. mem_addr and mem_wdata are stable for the whole state.
//   In RD/WR with mem_ready=1: transaction completes, return to IDLE next cycle.
//     RD also loads MonDReg <= mem_rdata. mem_ready=1 in the first RD/WR cycle gives a
//     1-cycle transaction.
//   Timeout: counter clears on entry and increments each cycle with mem_ready=0.
//     When it reaches TIMEOUT with mem_ready still 0: abort to IDLE, set mem_timeout.
//     MonDReg and MonAReg are left unchanged.
//  Any strobe while busy=1 (including the completion cycle) is dropped and sets cmd_overrun.
//  Simultaneous strobes in IDLE: execute only the highest priority; this is not an overrun.
//  MonAReg increment wraps modulo 2^ADDR_W (all-ones -> 0), with no flag.
//  cmd_overrun and mem_timeout clear only on reset.
//  busy is a registered output: it is 1 in the same cycles as mem_re|mem_we.
//  Reset asserted mid-transaction: mem_re/mem_we drop immediately (asynchronous) and all
//  state returns to the reset values.
// TESTING
//  1 Reset: hold reset_n=0 with random strobes -> all outputs 0; after release, busy=0.
//  2 Write burst, ADDR_W=8, mem_ready tied 1: ocimem_a jdo[24:17]=8'h10 jdo[35]=0, then
//    ocimem_b x3 with data A,B,C -> three 1-cycle writes at 0x10, 0x11, 0x12; final MonAReg=0x13.
//  3 Read with wait: ocimem_a addr=0x20 jdo[35]=1, mem_ready rises after 3 cycles with
//    rdata=32'hDEADBEEF -> mem_re high 4 cycles, MonDReg=DEADBEEF, MonAReg stays 0x20.
//  4 Wrap: MonAReg=0xFF, then no_action_a -> read at 0xFF; MonAReg=0x00 afterwards.
//  5 Overrun and priority: a second strobe while in RD -> dropped, cmd_overrun=1. In IDLE,
//    ocimem_a and ocimem_b in the same cycle -> only the write is issued.
//  6 Timeout: mem_ready held 0 with TIMEOUT=15 -> abort after 15 RD cycles, mem_timeout=1,
//    MonDReg unchanged; the next command is then accepted normally.

Source files
------------

// File: rtl/nios2_cpu_debug_ocimem_ctrl.sv
// Debug-memory access controller driven by the debug-slave sysclk strobes.
// Holds MonAReg/MonDReg and runs single read/write cycles with a timeout.
module nios2_cpu_debug_ocimem_ctrl #(
    parameter int ADDR_W  = 8,
    parameter int TIMEOUT = 15
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [37:0]       jdo,
    input  logic              take_action_ocimem_a,
    input  logic              take_no_action_ocimem_a,
    input  logic              take_action_ocimem_b,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic              mem_we,
    output logic              mem_re,
    input  logic [31:0]       mem_rdata,
    input  logic              mem_ready,
    output logic [31:0]       MonDReg,
    output logic [ADDR_W-1:0] MonAReg,
    output logic              busy,
    output logic              cmd_overrun,
    output logic              mem_timeout
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RD   = 2'd1,
        S_WR   = 2'd2
    } state_t;

    state_t            r_state;
    state_t            w_state_nx;
    logic [ADDR_W-1:0] r_mon_a;
    logic [31:0]       r_mon_d;
    logic [ADDR_W-1:0] r_addr;
    logic [31:0]       r_wdata;
    logic [3:0]        r_cnt;
    logic              r_inc;
    logic              r_overrun;
    logic              r_timeout;

    logic              w_strobe;
    logic              w_last;
    logic              w_load_a;
    logic              w_go_ra;
    logic              w_go_rn;
    logic              w_go_wr;
    logic              w_done;
    logic              w_abort;
    logic [ADDR_W-1:0] w_jdo_addr;

    assign w_strobe   = take_action_ocimem_a | take_no_action_ocimem_a
                      | take_action_ocimem_b;
    assign w_last     = (r_cnt == 4'(TIMEOUT - 1));
    assign w_jdo_addr = jdo[17+ADDR_W-1:17];

    // State register; reset drops mem_re/mem_we at once.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) r_state <= S_IDLE;
        else          r_state <= w_state_nx;
    end

    // Command decode in IDLE (b > a > no_action_a), completion/abort otherwise.
    always_comb begin
        w_state_nx = r_state;
        w_load_a   = 1'b0;
        w_go_ra    = 1'b0;
        w_go_rn    = 1'b0;
        w_go_wr    = 1'b0;
        w_done     = 1'b0;
        w_abort    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (take_action_ocimem_b) begin
                    w_go_wr    = 1'b1;
                    w_state_nx = S_WR;
                end else if (take_action_ocimem_a) begin
                    w_load_a = 1'b1;
                    if (jdo[35]) begin
                        w_go_ra    = 1'b1;
                        w_state_nx = S_RD;
                    end
                end else if (take_no_action_ocimem_a) begin
                    w_go_rn    = 1'b1;
                    w_state_nx = S_RD;
                end
            end
            S_RD, S_WR: begin
                if (mem_ready) begin
                    w_done     = 1'b1;
                    w_state_nx = S_IDLE;
                end else if (w_last) begin
                    w_abort    = 1'b1;
                    w_state_nx = S_IDLE;
                end
            end
            default: w_state_nx = S_IDLE;
        endcase
    end

    // Monitor registers, request address/data, wait counter and sticky flags.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_mon_a   <= '0;
            r_mon_d   <= '0;
            r_addr    <= '0;
            r_wdata   <= '0;
            r_cnt     <= '0;
            r_inc     <= 1'b0;
            r_overrun <= 1'b0;
            r_timeout <= 1'b0;
        end else begin
            if (r_state == S_IDLE || w_done || w_abort) r_cnt <= '0;
            else                                         r_cnt <= r_cnt + 4'd1;
            if (w_strobe && r_state != S_IDLE) r_overrun <= 1'b1;
            if (w_abort) r_timeout <= 1'b1;
            if (w_go_wr) begin
                r_mon_d <= jdo[34:3];
                r_wdata <= jdo[34:3];
                r_addr  <= r_mon_a;
                r_inc   <= 1'b1;
            end
            if (w_load_a) r_mon_a <= w_jdo_addr;
            if (w_go_ra) begin
                r_addr <= w_jdo_addr;
                r_inc  <= 1'b0;
            end
            if (w_go_rn) begin
                r_addr <= r_mon_a;
                r_inc  <= 1'b1;
            end
            if (w_done) begin
                if (r_state == S_RD) r_mon_d <= mem_rdata;
                if (r_inc)           r_mon_a <= r_mon_a + 1'b1;
            end
        end
    end

    assign mem_re      = (r_state == S_RD);
    assign mem_we      = (r_state == S_WR);
    assign busy        = (r_state != S_IDLE);
    assign mem_addr    = r_addr;
    assign mem_wdata   = r_wdata;
    assign MonDReg     = r_mon_d;
    assign MonAReg     = r_mon_a;
    assign cmd_overrun = r_overrun;
    assign mem_timeout = r_timeout;

endmodule

// File: tb/tb_nios2_cpu_debug_ocimem_ctrl.sv
// Directed bench for the debug-memory access controller.
// Inputs change on the falling edge; outputs are checked there too.
module tb_nios2_cpu_debug_ocimem_ctrl;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [37:0] jdo;
    logic        sa, sna, sb;
    logic [7:0]  mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_we, mem_re;
    logic [31:0] mem_rdata;
    logic        mem_ready;
    logic [31:0] MonDReg;
    logic [7:0]  MonAReg;
    logic        busy, cmd_overrun, mem_timeout;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    nios2_cpu_debug_ocimem_ctrl #(.ADDR_W(8), .TIMEOUT(15)) dut (
        .clk(clk), .reset_n(reset_n), .jdo(jdo),
        .take_action_ocimem_a(sa),
        .take_no_action_ocimem_a(sna),
        .take_action_ocimem_b(sb),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_we(mem_we), .mem_re(mem_re),
        .mem_rdata(mem_rdata), .mem_ready(mem_ready),
        .MonDReg(MonDReg), .MonAReg(MonAReg), .busy(busy),
        .cmd_overrun(cmd_overrun), .mem_timeout(mem_timeout)
    );

    function automatic logic [37:0] jdo_a(input logic [7:0] a, input logic rd);
        logic [37:0] j;
        j = '0;
        j[24:17] = a;
        j[35] = rd;
        return j;
    endfunction

    function automatic logic [37:0] jdo_b(input logic [31:0] d);
        logic [37:0] j;
        j = '0;
        j[34:3] = d;
        return j;
    endfunction

    // Called on a falling edge; returns on the next falling edge.
    task automatic pulse(input logic a, input logic na, input logic b,
                         input logic [37:0] j);
        sa = a; sna = na; sb = b; jdo = j;
        @(negedge clk);
        sa = 0; sna = 0; sb = 0;
    endtask

    task automatic test_reset();
        reset_n = 0;
        for (int i = 0; i < 6; i++) begin
            sa = 1'($urandom); sna = 1'($urandom); sb = 1'($urandom);
            jdo = {6'($urandom), 32'($urandom)};
            mem_ready = 1'($urandom);
            @(negedge clk);
            n_tests++;
            if ({mem_addr, mem_wdata, mem_we, mem_re, MonDReg, MonAReg,
                 busy, cmd_overrun, mem_timeout} !== '0) begin
                n_fail++;
                $display("FAIL reset_outputs: busy=%b re=%b we=%b A=%h D=%h", busy,
                         mem_re, mem_we, MonAReg, MonDReg);
            end
        end
        sa = 0; sna = 0; sb = 0; jdo = '0; mem_ready = 0;
        reset_n = 1;
        @(negedge clk);
        n_tests++;
        if (busy !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_release_busy: got %b want 0", busy);
        end
    endtask

    task automatic test_write_burst();
        logic [31:0] d [3];
        d[0] = 32'hAAAA_0001; d[1] = 32'hBBBB_0002; d[2] = 32'hCCCC_0003;
        mem_ready = 1;
        pulse(1, 0, 0, jdo_a(8'h10, 1'b0));
        n_tests++;
        if (MonAReg !== 8'h10 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL wr_load_addr: A=%h busy=%b want 10/0", MonAReg, busy);
        end
        for (int i = 0; i < 3; i++) begin
            pulse(0, 0, 1, jdo_b(d[i]));
            n_tests++;
            if (mem_we !== 1'b1 || mem_re !== 1'b0 || busy !== 1'b1 ||
                mem_addr !== 8'(8'h10 + i) || mem_wdata !== d[i]) begin
                n_fail++;
                $display("FAIL wr_cycle%0d: we=%b addr=%h wd=%h want 1/%h/%h",
                         i, mem_we, mem_addr, mem_wdata, 8'(8'h10 + i), d[i]);
            end
            @(negedge clk);
            n_tests++;
            if (mem_we !== 1'b0 || MonAReg !== 8'(8'h11 + i) || MonDReg !== d[i]) begin
                n_fail++;
                $display("FAIL wr_done%0d: we=%b A=%h D=%h want 0/%h/%h",
                         i, mem_we, MonAReg, MonDReg, 8'(8'h11 + i), d[i]);
            end
        end
        n_tests++;
        if (MonAReg !== 8'h13) begin
            n_fail++;
            $display("FAIL wr_final_addr: got %h want 13", MonAReg);
        end
    endtask

    task automatic test_read_wait();
        int cnt;
        cnt = 0;
        mem_ready = 0;
        mem_rdata = 32'hDEADBEEF;
        pulse(1, 0, 0, jdo_a(8'h20, 1'b1));
        n_tests++;
        if (mem_re !== 1'b1 || mem_addr !== 8'h20) begin
            n_fail++;
            $display("FAIL rd_issue: re=%b addr=%h want 1/20", mem_re, mem_addr);
        end
        for (int i = 0; i < 20; i++) begin
            if (mem_re) cnt++;
            else break;
            mem_ready = (cnt == 4);
            @(negedge clk);
        end
        mem_ready = 0;
        n_tests++;
        if (cnt != 4) begin
            n_fail++;
            $display("FAIL rd_re_cycles: got %0d want 4", cnt);
        end
        n_tests++;
        if (MonDReg !== 32'hDEADBEEF || MonAReg !== 8'h20) begin
            n_fail++;
            $display("FAIL rd_result: D=%h A=%h want DEADBEEF/20", MonDReg, MonAReg);
        end
    endtask

    task automatic test_wrap();
        mem_ready = 1;
        mem_rdata = 32'h1234_5678;
        pulse(1, 0, 0, jdo_a(8'hFF, 1'b0));
        pulse(0, 1, 0, '0);
        n_tests++;
        if (mem_re !== 1'b1 || mem_addr !== 8'hFF) begin
            n_fail++;
            $display("FAIL wrap_issue: re=%b addr=%h want 1/ff", mem_re, mem_addr);
        end
        @(negedge clk);
        n_tests++;
        if (MonAReg !== 8'h00 || MonDReg !== 32'h1234_5678 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL wrap_result: A=%h D=%h busy=%b want 00/12345678/0",
                     MonAReg, MonDReg, busy);
        end
    endtask

    task automatic test_overrun_priority();
        mem_ready = 0;
        mem_rdata = 32'h0BAD_F00D;
        n_tests++;
        if (cmd_overrun !== 1'b0) begin
            n_fail++;
            $display("FAIL ovr_pre: got %b want 0", cmd_overrun);
        end
        pulse(0, 1, 0, '0);
        pulse(0, 0, 1, jdo_b(32'h5555_AAAA));
        n_tests++;
        if (cmd_overrun !== 1'b1 || mem_re !== 1'b1 || mem_we !== 1'b0) begin
            n_fail++;
            $display("FAIL ovr_drop: ovr=%b re=%b we=%b want 1/1/0",
                     cmd_overrun, mem_re, mem_we);
        end
        mem_ready = 1;
        @(negedge clk);
        n_tests++;
        if (busy !== 1'b0 || MonAReg !== 8'h01 || MonDReg !== 32'h0BAD_F00D) begin
            n_fail++;
            $display("FAIL ovr_complete: busy=%b A=%h D=%h want 0/01/0badf00d",
                     busy, MonAReg, MonDReg);
        end
        pulse(1, 0, 1, jdo_b(32'hCAFE_0042) | jdo_a(8'h00, 1'b1));
        n_tests++;
        if (mem_we !== 1'b1 || mem_re !== 1'b0 || mem_addr !== 8'h01 ||
            mem_wdata !== 32'hCAFE_0042) begin
            n_fail++;
            $display("FAIL prio_issue: we=%b re=%b addr=%h wd=%h want 1/0/01/cafe0042",
                     mem_we, mem_re, mem_addr, mem_wdata);
        end
        @(negedge clk);
        n_tests++;
        if (MonAReg !== 8'h02 || MonDReg !== 32'hCAFE_0042) begin
            n_fail++;
            $display("FAIL prio_done: A=%h D=%h want 02/cafe0042", MonAReg, MonDReg);
        end
    endtask

    task automatic test_timeout();
        int cnt;
        cnt = 0;
        mem_ready = 0;
        mem_rdata = 32'hFFFF_FFFF;
        pulse(0, 1, 0, '0);
        for (int i = 0; i < 40; i++) begin
            if (mem_re) cnt++;
            else break;
            @(negedge clk);
        end
        n_tests++;
        if (cnt != 15) begin
            n_fail++;
            $display("FAIL to_cycles: got %0d want 15", cnt);
        end
        n_tests++;
        if (mem_timeout !== 1'b1 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL to_flag: to=%b busy=%b want 1/0", mem_timeout, busy);
        end
        n_tests++;
        if (MonDReg !== 32'hCAFE_0042 || MonAReg !== 8'h02) begin
            n_fail++;
            $display("FAIL to_regs: D=%h A=%h want cafe0042/02", MonDReg, MonAReg);
        end
        mem_ready = 1;
        pulse(0, 0, 1, jdo_b(32'h0000_7777));
        n_tests++;
        if (mem_we !== 1'b1 || mem_addr !== 8'h02) begin
            n_fail++;
            $display("FAIL to_next_cmd: we=%b addr=%h want 1/02", mem_we, mem_addr);
        end
        @(negedge clk);
        n_tests++;
        if (MonAReg !== 8'h03 || MonDReg !== 32'h0000_7777 || mem_timeout !== 1'b1) begin
            n_fail++;
            $display("FAIL to_next_done: A=%h D=%h to=%b want 03/00007777/1",
                     MonAReg, MonDReg, mem_timeout);
        end
    endtask

    task automatic test_async_reset();
        mem_ready = 0;
        pulse(0, 1, 0, '0);
        n_tests++;
        if (mem_re !== 1'b1) begin
            n_fail++;
            $display("FAIL ar_pre: re=%b want 1", mem_re);
        end
        #2;
        reset_n = 0;
        #1;
        n_tests++;
        if (mem_re !== 1'b0 || busy !== 1'b0 || MonAReg !== 8'h00 ||
            cmd_overrun !== 1'b0 || mem_timeout !== 1'b0 || MonDReg !== 32'h0) begin
            n_fail++;
            $display("FAIL ar_drop: re=%b busy=%b A=%h ovr=%b to=%b",
                     mem_re, busy, MonAReg, cmd_overrun, mem_timeout);
        end
        @(negedge clk);
        reset_n = 1;
        @(negedge clk);
    endtask

    initial begin
        reset_n = 0; sa = 0; sna = 0; sb = 0; jdo = '0;
        mem_rdata = '0; mem_ready = 0;
        @(negedge clk);
        test_reset();
        test_write_burst();
        test_read_wait();
        test_wrap();
        test_overrun_priority();
        test_timeout();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
